// File: rtl/tempfifo_axi_burst_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst writer and the DDR3 controller.
interface tempfifo_axi_burst_writer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/tempfifo_axi_burst_writer.sv
// Drains a 64-bit FWFT FIFO into a linear DDR3 region with fixed-length AXI4 INCR
// write bursts and pulses last_write once the final burst of the region is acknowledged.
module tempfifo_axi_burst_writer #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(32'h4000_0000),
    parameter int                BURST_LEN = 16,
    parameter int                CNT_W     = 11
) (
    input  logic                 ddrclk_i,
    input  logic                 reset_i,
    input  logic                 fifo_write_mem_en,
    input  logic [63:0]          tempfifo_data_i,
    input  logic [CNT_W-1:0]     tempfifo_rdcnt_i,
    input  logic                 tempfifo_empty_i,
    output logic                 tempfifo_re_o,
    tempfifo_axi_burst_writer_if.master m_axi,
    output logic                 last_write,
    output logic [ADDR_W-1:0]    wr_ptr_o,
    output logic [31:0]          burst_cnt_o,
    output logic                 resp_err_o,
    output logic                 busy_o
);
    localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
    localparam logic [CNT_W:0]    BURST_WORDS = (CNT_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 8);
    localparam logic [ADDR_W-1:0] END_ADDR    = BASE_ADDR + MEM_BYTES;

    typedef enum logic [2:0] {DONE, IDLE, ADDR, DATA, RESP} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        beat_q;
    logic [ADDR_W-1:0] ptr_next;
    logic              w_fire;

    // Fixed burst shape; write data comes straight from the FWFT head word.
    assign m_axi.awaddr  = wr_ptr_o;
    assign m_axi.awlen   = LAST_BEAT;
    assign m_axi.awsize  = 3'b011;
    assign m_axi.awburst = 2'b01;
    assign m_axi.wdata   = tempfifo_data_i;
    assign m_axi.wstrb   = 8'hFF;

    assign ptr_next = wr_ptr_o + BURST_BYTES;
    assign w_fire   = (state_q == DATA) && !tempfifo_empty_i && m_axi.wready;

    // State register; reset leaves the writer disarmed.
    always_ff @(posedge ddrclk_i) begin
        if (reset_i) state_q <= DONE;
        else         state_q <= state_d;
    end

    // Next-state and handshake outputs; a FIFO word is popped only on an accepted beat.
    always_comb begin
        state_d       = state_q;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.wlast   = 1'b0;
        m_axi.bready  = 1'b0;
        tempfifo_re_o = 1'b0;
        busy_o        = 1'b0;
        case (state_q)
            DONE: begin
                if (fifo_write_mem_en) state_d = IDLE;
            end
            IDLE: begin
                if ({1'b0, tempfifo_rdcnt_i} >= BURST_WORDS) state_d = ADDR;
            end
            ADDR: begin
                busy_o        = 1'b1;
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) state_d = DATA;
            end
            DATA: begin
                busy_o        = 1'b1;
                m_axi.wvalid  = !tempfifo_empty_i;
                m_axi.wlast   = (beat_q == LAST_BEAT);
                tempfifo_re_o = w_fire;
                if (w_fire && (beat_q == LAST_BEAT)) state_d = RESP;
            end
            RESP: begin
                busy_o       = 1'b1;
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) state_d = (ptr_next == END_ADDR) ? DONE : IDLE;
            end
            default: state_d = DONE;
        endcase
    end

    // Beat counter, region pointer, burst count, sticky error and the end-of-region pulse.
    always_ff @(posedge ddrclk_i) begin
        if (reset_i) begin
            beat_q      <= '0;
            wr_ptr_o    <= BASE_ADDR;
            burst_cnt_o <= '0;
            resp_err_o  <= 1'b0;
            last_write  <= 1'b0;
        end else begin
            last_write <= 1'b0;
            case (state_q)
                DONE: begin
                    if (fifo_write_mem_en) begin
                        wr_ptr_o    <= BASE_ADDR;
                        burst_cnt_o <= '0;
                        resp_err_o  <= 1'b0;
                    end
                end
                ADDR: begin
                    if (m_axi.awready) beat_q <= '0;
                end
                DATA: begin
                    if (w_fire) beat_q <= beat_q + 8'd1;
                end
                RESP: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp != 2'b00) resp_err_o <= 1'b1;
                        burst_cnt_o <= burst_cnt_o + 32'd1;
                        wr_ptr_o    <= ptr_next;
                        if (ptr_next == END_ADDR) last_write <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tempfifo_axi_burst_writer.sv
// Directed bench for the TEMPFIFO AXI burst writer with a 4-burst (0x200 byte) region.
`timescale 1ns/1ps
module tb_tempfifo_axi_burst_writer;
    localparam int          ADDR_W = 32;
    localparam int          CNT_W  = 11;
    localparam logic [31:0] MEM    = 32'h200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              arm;
    logic [63:0]       fdata;
    logic [CNT_W-1:0]  fcnt;
    logic              fempty;
    logic              fre;
    logic              last_write;
    logic [31:0]       wr_ptr;
    logic [31:0]       burst_cnt;
    logic              resp_err;
    logic              busy;

    tempfifo_axi_burst_writer_if #(.ADDR_W(ADDR_W)) m_axi();

    tempfifo_axi_burst_writer #(
        .ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .MEM_BYTES(MEM), .BURST_LEN(16), .CNT_W(CNT_W)
    ) dut (
        .ddrclk_i(clk), .reset_i(rst), .fifo_write_mem_en(arm),
        .tempfifo_data_i(fdata), .tempfifo_rdcnt_i(fcnt), .tempfifo_empty_i(fempty),
        .tempfifo_re_o(fre), .m_axi(m_axi), .last_write(last_write),
        .wr_ptr_o(wr_ptr), .burst_cnt_o(burst_cnt), .resp_err_o(resp_err), .busy_o(busy)
    );

    int n_total = 0, n_bad = 0;
    logic [63:0] fifo_q[$];
    logic [63:0] w_log[$];
    logic [31:0] aw_log[$];
    int next_word = 0, cyc = 0, err_at = -1;
    logic rnd = 1'b0, pop_pend = 1'b0, aw_prev_pend = 1'b0, arm_next = 1'b0, got = 1'b0;
    logic [31:0] aw_prev_addr = '0;
    int re_cnt = 0, b_total = 0, b_pend = 0, b_cycle = 0, lw_cnt = 0, lw_cycle = 0;
    int bb = 0, cur_beat = 0, wlast_bad = 0, underflow = 0, re_bad = 0, aw_drop = 0;
    int aw_seen = 0, aw_hdr_bad = 0;
    int re_base = 0, aw_base = 0, lw_base = 0, b_base = 0, seen_base = 0, n = 0, bad = 0;

    // Count one comparison and report a mismatch.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            fifo_q.push_back(64'(next_word));
            next_word++;
        end
    endtask

    // One clock: at the falling edge retire the popped word, drive FIFO/AXI inputs, then sample.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
        fdata  = (fifo_q.size() > 0) ? fifo_q[0] : 64'h0;
        fcnt   = CNT_W'(fifo_q.size());
        fempty = (fifo_q.size() == 0);
        m_axi.awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi.wready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_axi.bvalid  = (b_pend > 0) && (!rnd || $urandom_range(0, 1) == 1);
        m_axi.bresp   = (b_total == err_at) ? 2'b10 : 2'b00;
        #1;
        if (m_axi.awvalid) aw_seen++;
        if (aw_prev_pend && (!m_axi.awvalid || m_axi.awaddr != aw_prev_addr)) aw_drop++;
        aw_prev_pend = m_axi.awvalid && !m_axi.awready;
        aw_prev_addr = m_axi.awaddr;
        if (m_axi.awvalid && m_axi.awready) begin
            aw_log.push_back(m_axi.awaddr);
            if (m_axi.awlen != 8'd15 || m_axi.awsize != 3'b011 || m_axi.awburst != 2'b01) aw_hdr_bad++;
        end
        cur_beat = bb;
        if (m_axi.wvalid && m_axi.wready) begin
            w_log.push_back(m_axi.wdata);
            if (m_axi.wlast != (bb == 15) || m_axi.wstrb != 8'hFF) wlast_bad++;
            if (m_axi.wlast) b_pend++;
            bb = (bb == 15) ? 0 : bb + 1;
        end
        if (fre && fempty) underflow++;
        if (fre != (m_axi.wvalid && m_axi.wready)) re_bad++;
        if (fre) re_cnt++;
        if (m_axi.bvalid && m_axi.bready) begin
            b_total++;
            b_pend--;
            b_cycle = cyc;
        end
        if (last_write) begin
            lw_cnt++;
            lw_cycle = cyc;
        end
        pop_pend = fre;
    endtask

    task automatic run_until_b(input int target, input int budget, input string tag);
        int k = 0;
        while (b_total < target && k < budget) begin
            step();
            k++;
        end
        chk(tag, 64'(b_total), 64'(target));
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; fdata = '0; fcnt = '0; fempty = 1'b1;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;

        // Reset state
        repeat (3) step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_awvalid", 64'(m_axi.awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi.wvalid), 64'd0);
        chk("rst_bready", 64'(m_axi.bready), 64'd0);
        chk("rst_re", 64'(fre), 64'd0);
        chk("rst_last_write", 64'(last_write), 64'd0);
        chk("rst_wr_ptr", 64'(wr_ptr), 64'h0);
        chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);

        // Disarmed after reset: buffered data is left alone until armed
        rst = 1'b0;
        push(16);
        repeat (10) step();
        chk("done_no_read", 64'(re_cnt), 64'd0);
        chk("done_no_aw", 64'(aw_seen), 64'd0);

        // First burst: words 0..15 at address 0
        arm = 1'b1; step(); arm = 1'b0;
        run_until_b(1, 200, "b1_timeout");
        step();
        chk("b1_aw_count", 64'(aw_log.size()), 64'd1);
        chk("b1_aw_addr", 64'(aw_log[0]), 64'h0);
        chk("b1_w_count", 64'(w_log.size()), 64'd16);
        chk("b1_w_first", w_log[0], 64'd0);
        chk("b1_w_last", w_log[15], 64'd15);
        chk("b1_wlast_pos", 64'(wlast_bad), 64'd0);
        chk("b1_burst_cnt", 64'(burst_cnt), 64'd1);
        chk("b1_wr_ptr", 64'(wr_ptr), 64'h80);

        // 15 words never start a burst; the 16th does
        push(15);
        seen_base = aw_seen;
        re_base = re_cnt;
        repeat (100) step();
        chk("short_no_aw", 64'(aw_seen - seen_base), 64'd0);
        chk("short_no_read", 64'(re_cnt - re_base), 64'd0);
        push(1);
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (m_axi.awvalid) got = 1'b1;
        end
        chk("aw_within_2", 64'(got), 64'd1);
        err_at = 1;
        run_until_b(2, 200, "b2_timeout");
        step();
        chk("b2_resp_err", 64'(resp_err), 64'd1);
        chk("b2_burst_cnt", 64'(burst_cnt), 64'd2);
        chk("b2_wr_ptr", 64'(wr_ptr), 64'h100);

        // Last two bursts of the region, then last_write and DONE
        push(32);
        run_until_b(4, 400, "b4_timeout");
        step();
        step();
        chk("b3_aw_addr", 64'(aw_log[2]), 64'h100);
        chk("b4_aw_addr", 64'(aw_log[3]), 64'h180);
        chk("err_sticky", 64'(resp_err), 64'd1);
        chk("lw_count", 64'(lw_cnt), 64'd1);
        chk("lw_timing", 64'(lw_cycle), 64'(b_cycle + 1));
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_wr_ptr", 64'(wr_ptr), 64'h200);
        chk("end_burst_cnt", 64'(burst_cnt), 64'd4);
        push(16);
        re_base = re_cnt;
        seen_base = aw_seen;
        repeat (30) step();
        chk("end_no_read", 64'(re_cnt - re_base), 64'd0);
        chk("end_no_aw", 64'(aw_seen - seen_base), 64'd0);

        // Re-arm clears the run and restarts at the base address
        re_base = re_cnt; aw_base = aw_log.size(); lw_base = lw_cnt; b_base = b_total;
        arm = 1'b1; step(); arm = 1'b0;
        chk("rearm_wr_ptr", 64'(wr_ptr), 64'h0);
        chk("rearm_burst_cnt", 64'(burst_cnt), 64'd0);
        chk("rearm_resp_err", 64'(resp_err), 64'd0);

        // 64 bursts with random AW/W/B stalls, re-arming after each full region
        rnd = 1'b1;
        n = 0;
        while (b_total < b_base + 64 && n < 30000) begin
            if (next_word < 1088 && fifo_q.size() < 40 && $urandom_range(0, 1) == 1) push(1);
            arm = arm_next;
            arm_next = 1'b0;
            step();
            if (last_write) arm_next = 1'b1;
            n++;
        end
        arm = 1'b0;
        rnd = 1'b0;
        repeat (3) step();
        chk("rnd_b_count", 64'(b_total - b_base), 64'd64);
        chk("rnd_re_count", 64'(re_cnt - re_base), 64'd1024);
        chk("rnd_lw_count", 64'(lw_cnt - lw_base), 64'd16);
        bad = 0;
        for (int i = 0; i < 64; i++)
            if (aw_log.size() <= aw_base + i || aw_log[aw_base + i] != 32'((i % 4) * 128)) bad++;
        chk("rnd_aw_addrs", 64'(bad), 64'd0);
        chk("w_total", 64'(w_log.size()), 64'd1088);
        bad = 0;
        for (int i = 0; i < w_log.size(); i++)
            if (w_log[i] != 64'(i)) bad++;
        chk("w_order", 64'(bad), 64'd0);
        chk("wlast_beats", 64'(wlast_bad), 64'd0);
        chk("no_underflow", 64'(underflow), 64'd0);
        chk("re_is_w_fire", 64'(re_bad), 64'd0);
        chk("aw_stable", 64'(aw_drop), 64'd0);
        chk("aw_header", 64'(aw_hdr_bad), 64'd0);
        chk("rnd_end_busy", 64'(busy), 64'd0);

        // Reset while beat 7 of the second burst is on the bus
        push(32);
        arm = 1'b1; step(); arm = 1'b0;
        run_until_b(b_total + 1, 200, "pre_rst_timeout");
        step();
        chk("pre_rst_wr_ptr", 64'(wr_ptr), 64'h80);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_axi.wvalid && cur_beat == 7) begin
                got = 1'b1;
                break;
            end
        end
        chk("reach_beat7", 64'(got), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_awvalid", 64'(m_axi.awvalid), 64'd0);
        chk("mid_rst_wvalid", 64'(m_axi.wvalid), 64'd0);
        chk("mid_rst_wlast", 64'(m_axi.wlast), 64'd0);
        chk("mid_rst_bready", 64'(m_axi.bready), 64'd0);
        chk("mid_rst_re", 64'(fre), 64'd0);
        chk("mid_rst_wr_ptr", 64'(wr_ptr), 64'h0);
        chk("mid_rst_burst_cnt", 64'(burst_cnt), 64'd0);
        rst = 1'b0;
        re_base = re_cnt;
        repeat (10) step();
        chk("post_rst_no_read", 64'(re_cnt - re_base), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
